// File: rtl/apb_i2c_regif.sv
// apb_i2c_regif: APB slave register file in front of the I2C core.
// Six-register map, FIFO wait states with timeout, PSLVERR, W1C interrupt.
// Ports:
//   PCLK, PRESET                     clock, async active-high reset
//   PSELx, PENABLE, PWRITE, PADDR,   APB request
//   PWDATA
//   PRDATA, PREADY, PSLVERR          APB response
//   TX_FULL, TX_EMPTY, RX_EMPTY,     I2C core status
//   ERROR
//   RX_DATA, RD_ENA                  RX FIFO head word and pop
//   TX_DATA, WR_ENA                  TX FIFO word and push
//   I2C_CONFIG                       configuration register
//   INT                              |(INT_STAT & INT_EN)
module apb_i2c_regif #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int CFG_W    = 14,
    parameter int WAIT_MAX = 15
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSELx,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic              TX_FULL,
    input  logic              TX_EMPTY,
    input  logic              RX_EMPTY,
    input  logic              ERROR,
    input  logic [DATA_W-1:0] RX_DATA,
    output logic [DATA_W-1:0] TX_DATA,
    output logic              WR_ENA,
    output logic              RD_ENA,
    output logic [CFG_W-1:0]  I2C_CONFIG,
    output logic              INT
);

    // SETUP: setup phase seen last cycle, first access cycle expected.
    // ACCESS: access is being stalled by a FIFO.
    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CFG_W-1:0] r_cfg;
    logic [3:0]       r_int_en;
    logic [3:0]       r_int_stat;
    logic [7:0]       r_wait;
    logic             r_tx_empty_q;
    logic             r_rx_empty_q;
    logic             r_error_q;

    logic [ADDR_W-3:0] w_idx;
    logic [2:0]        w_reg;
    logic              w_mapped;
    logic              w_dec_err;
    logic              w_tx;
    logic              w_rx;
    logic              w_busy;
    logic              w_tmo;
    logic              w_acc;
    logic              w_perr;
    logic              w_ready;
    logic              w_slverr;
    logic              w_wr_ok;
    logic [DATA_W-1:0] w_rdata;
    logic [3:0]        w_set;
    logic [3:0]        w_clr;

    assign w_idx    = PADDR[ADDR_W-1:2];
    assign w_reg    = w_idx[2:0];
    assign w_mapped = (PADDR[1:0] == 2'b00)
                   && (w_idx < (ADDR_W-2)'(6));

    assign w_dec_err = !w_mapped
        || (!PWRITE && w_reg == 3'd0)
        || (PWRITE && (w_reg == 3'd1 || w_reg == 3'd3));

    assign w_tx   = w_mapped && PWRITE && w_reg == 3'd0;
    assign w_rx   = w_mapped && !PWRITE && w_reg == 3'd1;
    assign w_busy = (w_tx && TX_FULL) || (w_rx && RX_EMPTY);
    assign w_tmo  = w_busy && (r_wait == 8'(WAIT_MAX));

    // Outputs are forced low while reset is held, even if the bus
    // still shows an access phase.
    assign w_acc  = !PRESET && PSELx && PENABLE
                 && (r_state != S_IDLE);
    assign w_perr = !PRESET && PSELx && PENABLE
                 && (r_state == S_IDLE);

    always_comb begin
        case (w_reg)
            3'd1:    w_rdata = RX_DATA;
            3'd2:    w_rdata = DATA_W'(r_cfg);
            3'd3:    w_rdata = DATA_W'({ERROR, RX_EMPTY,
                                        TX_FULL, TX_EMPTY});
            3'd4:    w_rdata = DATA_W'(r_int_en);
            3'd5:    w_rdata = DATA_W'(r_int_stat);
            default: w_rdata = '0;
        endcase
    end

    always_comb begin
        w_ready  = 1'b0;
        w_slverr = 1'b0;
        WR_ENA   = 1'b0;
        RD_ENA   = 1'b0;
        PRDATA   = '0;
        if (w_perr) begin
            w_ready  = 1'b1;
            w_slverr = 1'b1;
        end else if (w_acc) begin
            if (w_dec_err) begin
                w_ready  = 1'b1;
                w_slverr = 1'b1;
            end else if (w_busy) begin
                w_ready  = w_tmo;
                w_slverr = w_tmo;
            end else begin
                w_ready = 1'b1;
                WR_ENA  = w_tx;
                RD_ENA  = w_rx;
                if (!PWRITE) begin
                    PRDATA = w_rdata;
                end
            end
        end
    end

    assign PREADY  = w_ready;
    assign PSLVERR = w_slverr;
    assign w_wr_ok = w_acc && w_ready && !w_slverr && PWRITE;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (PSELx && !PENABLE) begin
                    w_next = S_SETUP;
                end
            end
            S_SETUP, S_ACCESS: begin
                if (!PSELx) begin
                    w_next = S_IDLE;
                end else if (PENABLE) begin
                    w_next = w_ready ? S_IDLE : S_ACCESS;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Event set takes priority over a same-cycle W1C clear.
    assign w_set = {w_acc && w_tmo,
                    ERROR && !r_error_q,
                    r_rx_empty_q && !RX_EMPTY,
                    TX_EMPTY && !r_tx_empty_q};
    assign w_clr = (w_wr_ok && w_reg == 3'd5) ? PWDATA[3:0] : 4'd0;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_cfg        <= '0;
            r_int_en     <= '0;
            r_int_stat   <= '0;
            r_wait       <= '0;
            r_tx_empty_q <= 1'b1;
            r_rx_empty_q <= 1'b1;
            r_error_q    <= 1'b0;
        end else begin
            if (w_acc && w_busy && !w_tmo) begin
                r_wait <= r_wait + 8'd1;
            end else begin
                r_wait <= '0;
            end
            if (w_wr_ok && w_reg == 3'd2) begin
                r_cfg <= PWDATA[CFG_W-1:0];
            end
            if (w_wr_ok && w_reg == 3'd4) begin
                r_int_en <= PWDATA[3:0];
            end
            r_int_stat   <= (r_int_stat & ~w_clr) | w_set;
            r_tx_empty_q <= TX_EMPTY;
            r_rx_empty_q <= RX_EMPTY;
            r_error_q    <= ERROR;
        end
    end

    assign TX_DATA    = PWDATA;
    assign I2C_CONFIG = r_cfg;
    assign INT        = |(r_int_stat & r_int_en);

endmodule
